branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, number of direct-mapped entries; it must be a power of two and at least 2.
REQ-002 The block SHALL use derived IDX_W = log2(ENTRIES); index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2].
REQ-003 The block SHALL have port iClk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port iRst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port iFetchPC, input, 32, fetch-stage PC being looked up.
REQ-006 The block SHALL have port oPredTaken, output, 1, predict redirect for iFetchPC.
REQ-007 The block SHALL have port oPredTarget, output, 32, predicted next PC.
REQ-008 The block SHALL have port iUpdValid, input, 1, resolved control-transfer instruction from execute this cycle.
REQ-009 The block SHALL have port iUpdPC, input, 32, PC of the resolved instruction.
REQ-010 The block SHALL have port iUpdTaken, input, 1, resolved direction.
REQ-011 The block SHALL have port iUpdTarget, input, 32, resolved target from the execute-stage PC target adder.
REQ-012 The block SHALL have port iUpdIsJump, input, 1, instruction is JAL/JALR (unconditional).
REQ-013 The block SHALL have ports iUpdPredTaken (input, 1) and iUpdPredTarget (input, 32), the prediction that fetch carried down the pipe for this instruction.
REQ-014 The block SHALL have port oMispredict, output, 1, resolved outcome differs from the carried prediction.
REQ-015 The block SHALL have port iInvalidate, input, 1, clear all entries (fence.i/context flush).

Function
REQ-016 Each entry SHALL hold valid (1b), tag, target[31:2], and a 2-bit saturating counter.
REQ-017 Lookup SHALL be combinational; hit = valid && stored tag == tag(iFetchPC).
REQ-018 On hit with counter[1]=1, outputs SHALL be oPredTaken=1 and oPredTarget={target,2'b00}; otherwise oPredTaken=0 and oPredTarget=iFetchPC+4 (mod 2^32; 0xFFFFFFFC wraps to 0).
REQ-019 Update SHALL occur when iUpdValid=1. On a hit at the update index, the counter saturates: increments when taken (max 11), decrements when not taken (min 00), and the target is written when taken.
REQ-020 On an update miss with iUpdTaken=1, the entry SHALL be replaced (no victim choice): valid=1, tag, target=iUpdTarget[31:2], counter=10.
REQ-021 On an update miss with iUpdTaken=0, the entry SHALL be left unchanged.
REQ-022 When iUpdIsJump=1, the counter SHALL be forced to 11 on both hit and miss, regardless of prior state.
REQ-023 Stored targets SHALL drop iUpdTarget[1:0]; the predicted target is always word aligned.
REQ-024 oMispredict SHALL be combinational and equal iUpdValid && ((iUpdPredTaken != iUpdTaken) || (iUpdTaken && iUpdPredTarget != {iUpdTarget[31:2],2'b00})); it SHALL be 0 when iUpdValid=0.
REQ-025 When iInvalidate=1, all valid bits SHALL clear at the next edge; iInvalidate takes priority over a same-cycle update, which is discarded.
REQ-026 Updates SHALL have a one-cycle latency: a lookup in the cycle after the update edge sees the new contents.

Reset
REQ-027 On iRst=1 at an edge, all valid bits SHALL be set to 0, all counters to 01, and all targets to 0; iRst overrides iInvalidate and updates.
REQ-028 Reset asserted mid-operation SHALL discard any same-cycle update.
REQ-029 While no entry is valid, outputs SHALL be oPredTaken=0 and oPredTarget=iFetchPC+4; oMispredict depends only on inputs.

Configuration
REQ-030 The block SHALL support macro BTB_BYPASS_EN. When defined, a lookup whose index matches a same-cycle qualifying update (not suppressed by iInvalidate/iRst) returns the post-update entry combinationally. When undefined, such a lookup returns the pre-update contents.

Verification
REQ-031 Reset then iFetchPC=0x100 SHALL give oPredTaken=0 and oPredTarget=0x104.
REQ-032 Update PC=0x100, taken, target=0x83; next cycle, fetch 0x100 SHALL give oPredTaken=1 and oPredTarget=0x80.
REQ-033 From REQ-032 state, two not-taken updates at 0x100 SHALL make the counter 00; fetch 0x100 SHALL then give oPredTaken=0 and oPredTarget=0x104.
REQ-034 Taken update 0x140 with target 0x200 (index 0, different tag) after REQ-032 SHALL make fetch 0x100 miss and fetch 0x140 predict 0x200.
REQ-035 iInvalidate=1 together with a taken update at 0x100 SHALL make the next-cycle fetch 0x100 miss; iUpdValid=1, PredTaken=0, Taken=1 SHALL give oMispredict=1.
REQ-036 A same-cycle taken update and fetch at 0x100 (empty BTB) SHALL give oPredTaken=1 and oPredTarget=0x80 with BTB_BYPASS_EN, and oPredTaken=0 and oPredTarget=0x104 without it.

Source files
------------

// File: rtl/branch_target_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with 2-bit saturating direction counters,
//               combinational lookup and single-port resolve-time update.
//               Optional macro BTB_BYPASS_EN forwards a same-cycle update
//               to the lookup port.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [31:0] iFetchPC,
    output logic        oPredTaken,
    output logic [31:0] oPredTarget,
    input  logic        iUpdValid,
    input  logic [31:0] iUpdPC,
    input  logic        iUpdTaken,
    input  logic [31:0] iUpdTarget,
    input  logic        iUpdIsJump,
    input  logic        iUpdPredTaken,
    input  logic [31:0] iUpdPredTarget,
    output logic        oMispredict,
    input  logic        iInvalidate
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_we;
    logic             w_upd_qual;
    logic             w_nxt_valid;
    logic [TAG_W-1:0] w_nxt_tag;
    logic [29:0]      w_nxt_target;
    logic [1:0]       w_nxt_ctr;

    logic [IDX_W-1:0] w_fetch_idx;
    logic [TAG_W-1:0] w_fetch_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [29:0]      w_rd_target;
    logic [1:0]       w_rd_ctr;
    logic             w_fetch_hit;

    // Address bits below word granularity carry no information here.
    logic             w_unused_bits;
    assign w_unused_bits = ^{iUpdPC[1:0], iUpdTarget[1:0]};

    assign w_upd_idx  = iUpdPC[IDX_W+1:2];
    assign w_upd_tag  = iUpdPC[31:IDX_W+2];
    assign w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_qual = iUpdValid && !iInvalidate && !iRst;

    // Post-update image of the entry selected by the update index.
    always_comb begin
        w_nxt_valid  = r_valid[w_upd_idx];
        w_nxt_tag    = r_tag[w_upd_idx];
        w_nxt_target = r_target[w_upd_idx];
        w_nxt_ctr    = r_ctr[w_upd_idx];
        w_upd_we     = 1'b0;
        if (w_upd_hit) begin
            w_upd_we = 1'b1;
            if (iUpdIsJump) begin
                w_nxt_ctr = 2'b11;
            end else if (iUpdTaken) begin
                if (r_ctr[w_upd_idx] != 2'b11) begin
                    w_nxt_ctr = r_ctr[w_upd_idx] + 2'b01;
                end
            end else begin
                if (r_ctr[w_upd_idx] != 2'b00) begin
                    w_nxt_ctr = r_ctr[w_upd_idx] - 2'b01;
                end
            end
            if (iUpdTaken) begin
                w_nxt_target = iUpdTarget[31:2];
            end
        end else if (iUpdTaken) begin
            w_upd_we     = 1'b1;
            w_nxt_valid  = 1'b1;
            w_nxt_tag    = w_upd_tag;
            w_nxt_target = iUpdTarget[31:2];
            w_nxt_ctr    = iUpdIsJump ? 2'b11 : 2'b10;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (iInvalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_upd_qual && w_upd_we) begin
            r_valid[w_upd_idx]  <= w_nxt_valid;
            r_tag[w_upd_idx]    <= w_nxt_tag;
            r_target[w_upd_idx] <= w_nxt_target;
            r_ctr[w_upd_idx]    <= w_nxt_ctr;
        end
    end

    assign w_fetch_idx = iFetchPC[IDX_W+1:2];
    assign w_fetch_tag = iFetchPC[31:IDX_W+2];

`ifdef BTB_BYPASS_EN
    logic w_byp;
    assign w_byp       = w_upd_qual && w_upd_we && (w_upd_idx == w_fetch_idx);
    assign w_rd_valid  = w_byp ? w_nxt_valid  : r_valid[w_fetch_idx];
    assign w_rd_tag    = w_byp ? w_nxt_tag    : r_tag[w_fetch_idx];
    assign w_rd_target = w_byp ? w_nxt_target : r_target[w_fetch_idx];
    assign w_rd_ctr    = w_byp ? w_nxt_ctr    : r_ctr[w_fetch_idx];
`else
    assign w_rd_valid  = r_valid[w_fetch_idx];
    assign w_rd_tag    = r_tag[w_fetch_idx];
    assign w_rd_target = r_target[w_fetch_idx];
    assign w_rd_ctr    = r_ctr[w_fetch_idx];
`endif

    assign w_fetch_hit = w_rd_valid && (w_rd_tag == w_fetch_tag);
    assign oPredTaken  = w_fetch_hit && w_rd_ctr[1];
    assign oPredTarget = oPredTaken ? {w_rd_target, 2'b00} : (iFetchPC + 32'd4);

    assign oMispredict = iUpdValid &&
                         ((iUpdPredTaken != iUpdTaken) ||
                          (iUpdTaken && (iUpdPredTarget != {iUpdTarget[31:2], 2'b00})));

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`timescale 1ns/1ps
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        iRst, iUpdValid, iUpdTaken, iUpdIsJump, iUpdPredTaken, iInvalidate;
    logic [31:0] iFetchPC, iUpdPC, iUpdTarget, iUpdPredTarget;
    logic        oPredTaken, oMispredict;
    logic [31:0] oPredTarget;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .iClk(clk), .iRst(iRst), .iFetchPC(iFetchPC),
        .oPredTaken(oPredTaken), .oPredTarget(oPredTarget),
        .iUpdValid(iUpdValid), .iUpdPC(iUpdPC), .iUpdTaken(iUpdTaken),
        .iUpdTarget(iUpdTarget), .iUpdIsJump(iUpdIsJump),
        .iUpdPredTaken(iUpdPredTaken), .iUpdPredTarget(iUpdPredTarget),
        .oMispredict(oMispredict), .iInvalidate(iInvalidate)
    );

    typedef struct {
        bit rst, inv, uv, ut, uj, upt;
        bit [31:0] upc, utgt, uptgt, fpc;
        bit e_tk;
        bit [31:0] e_tg;
        bit e_mis;
    } vec_t;
    vec_t vq[$];

    typedef struct {
        bit v;
        bit [31:0] pc;
        bit [31:0] tgt;
        int ctr;
    } ment_t;
    ment_t m[ENTRIES];
    ment_t m_nx[ENTRIES];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input bit rst, input bit inv, input bit uv, input bit ut,
                           input bit uj, input bit upt, input bit [31:0] upc,
                           input bit [31:0] utgt, input bit [31:0] uptgt,
                           input bit [31:0] fpc, input bit e_tk,
                           input bit [31:0] e_tg, input bit e_mis);
        vec_t v;
        v.rst = rst; v.inv = inv; v.uv = uv; v.ut = ut; v.uj = uj; v.upt = upt;
        v.upc = upc; v.utgt = utgt; v.uptgt = uptgt; v.fpc = fpc;
        v.e_tk = e_tk; v.e_tg = e_tg; v.e_mis = e_mis;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        iRst = v.rst; iInvalidate = v.inv; iUpdValid = v.uv; iUpdTaken = v.ut;
        iUpdIsJump = v.uj; iUpdPredTaken = v.upt; iUpdPC = v.upc;
        iUpdTarget = v.utgt; iUpdPredTarget = v.uptgt; iFetchPC = v.fpc;
    endtask

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % 32'(ENTRIES));
    endfunction

    function automatic bit same_tag(input bit [31:0] a, input bit [31:0] b);
        return (a / (32'(ENTRIES) * 4)) == (b / (32'(ENTRIES) * 4));
    endfunction

    task automatic model_step(input bit rst, input bit inv, input bit uv, input bit ut,
                              input bit uj, input bit [31:0] upc, input bit [31:0] utgt);
        int i;
        m_nx = m;
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_nx[k].v = 1'b0; m_nx[k].pc = 0; m_nx[k].tgt = 0; m_nx[k].ctr = 1;
            end
        end else if (inv) begin
            for (int k = 0; k < ENTRIES; k++) m_nx[k].v = 1'b0;
        end else if (uv) begin
            i = idx_of(upc);
            if (m[i].v && same_tag(m[i].pc, upc)) begin
                if (uj) m_nx[i].ctr = 3;
                else if (ut) m_nx[i].ctr = (m[i].ctr < 3) ? m[i].ctr + 1 : 3;
                else m_nx[i].ctr = (m[i].ctr > 0) ? m[i].ctr - 1 : 0;
                if (ut) m_nx[i].tgt = utgt & 32'hFFFF_FFFC;
            end else if (ut) begin
                m_nx[i].v = 1'b1; m_nx[i].pc = upc;
                m_nx[i].tgt = utgt & 32'hFFFF_FFFC;
                m_nx[i].ctr = uj ? 3 : 2;
            end
        end
    endtask

    task automatic model_predict(input bit use_nx, input bit [31:0] pc,
                                 output bit tk, output bit [31:0] tg);
        ment_t e;
        e = use_nx ? m_nx[idx_of(pc)] : m[idx_of(pc)];
        if (e.v && same_tag(e.pc, pc) && e.ctr >= 2) begin
            tk = 1'b1; tg = e.tgt;
        end else begin
            tk = 1'b0; tg = pc + 32'd4;
        end
    endtask

    function automatic bit [31:0] rpc();
        bit [31:0] p;
        p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) p = p | 32'hFFFF_FF00;
        return p;
    endfunction

    initial begin
        vec_t v;
        bit rst, inv, uv, ut, uj, upt, e_tk, e_mis, qual;
        bit [31:0] upc, utgt, uptgt, fpc, e_tg;

        iRst = 1'b1; iInvalidate = 0; iUpdValid = 0; iUpdTaken = 0; iUpdIsJump = 0;
        iUpdPredTaken = 0; iUpdPC = 0; iUpdTarget = 0; iUpdPredTarget = 0; iFetchPC = 0;
        repeat (2) @(posedge clk);

        // rst inv uv ut uj upt  upc  utgt  uptgt  fpc   exp_tk exp_tg exp_mis
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'hFFFF_FFFC, 0, 32'h0, 0);
        add_vec(0,0,1,1,0,0, 32'h100, 32'h83,  32'h0,   32'h100, BYP, BYP ? 32'h80 : 32'h104, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 1, 32'h80, 0);
        add_vec(0,0,1,0,0,1, 32'h100, 32'h0,   32'h80,  32'h100, !BYP, BYP ? 32'h104 : 32'h80, 1);
        add_vec(0,0,1,0,0,0, 32'h100, 32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,1,1,0,0, 32'h100, 32'h80,  32'h0,   32'h104, 0, 32'h108, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,1,1,0,0, 32'h100, 32'h80,  32'h0,   32'h200, 0, 32'h204, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 1, 32'h80, 0);
        add_vec(0,0,1,1,0,1, 32'h140, 32'h200, 32'h200, 32'h140, BYP, BYP ? 32'h200 : 32'h144, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h140, 1, 32'h200, 0);
        add_vec(0,0,1,1,1,1, 32'h180, 32'h302, 32'h300, 32'h300, 0, 32'h304, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h180, 1, 32'h300, 0);
        add_vec(0,0,1,0,0,1, 32'h180, 32'h0,   32'h300, 32'h180, 1, 32'h300, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h180, 1, 32'h300, 0);
        add_vec(0,1,1,1,0,0, 32'h100, 32'h83,  32'h0,   32'h180, 1, 32'h300, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h100, 0, 32'h104, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h180, 0, 32'h184, 0);
        add_vec(0,0,0,1,0,0, 32'h10,  32'h40,  32'h0,   32'h10,  0, 32'h14, 0);
        add_vec(0,0,1,1,0,1, 32'h20,  32'h44,  32'h48,  32'h24,  0, 32'h28, 1);
        add_vec(1,0,1,1,0,0, 32'h24,  32'h50,  32'h0,   32'h20,  1, 32'h44, 1);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h20,  0, 32'h24, 0);
        add_vec(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h24,  0, 32'h28, 0);

        for (int r = 0; r < vq.size(); r++) begin
            @(negedge clk);
            drive(vq[r]);
            #1;
            chk($sformatf("row%0d taken", r), 32'(oPredTaken), 32'(vq[r].e_tk));
            chk($sformatf("row%0d target", r), oPredTarget, vq[r].e_tg);
            chk($sformatf("row%0d mispredict", r), 32'(oMispredict), 32'(vq[r].e_mis));
            @(posedge clk);
        end

        // Randomized phase against the reference model, starting from reset.
        @(negedge clk);
        v = '{default: 0};
        v.rst = 1'b1;
        drive(v);
        @(posedge clk);
        for (int k = 0; k < ENTRIES; k++) begin
            m[k].v = 1'b0; m[k].pc = 0; m[k].tgt = 0; m[k].ctr = 1;
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            inv   = ($urandom_range(0, 39) == 0);
            uv    = ($urandom_range(0, 3) != 0);
            uj    = ($urandom_range(0, 5) == 0);
            ut    = uj ? 1'b1 : 1'($urandom_range(0, 1));
            upt   = 1'($urandom_range(0, 1));
            upc   = rpc();
            utgt  = $urandom;
            uptgt = ($urandom_range(0, 1) == 1) ? (utgt & 32'hFFFF_FFFC) : $urandom;
            fpc   = ($urandom_range(0, 3) == 0) ? upc : rpc();
            v.rst = rst; v.inv = inv; v.uv = uv; v.ut = ut; v.uj = uj; v.upt = upt;
            v.upc = upc; v.utgt = utgt; v.uptgt = uptgt; v.fpc = fpc;
            drive(v);
            model_step(rst, inv, uv, ut, uj, upc, utgt);
            qual = uv && !inv && !rst;
            model_predict(BYP && qual, fpc, e_tk, e_tg);
            e_mis = uv && ((upt != ut) || (ut && uptgt != (utgt & 32'hFFFF_FFFC)));
            #1;
            chk($sformatf("rnd%0d taken", c), 32'(oPredTaken), 32'(e_tk));
            chk($sformatf("rnd%0d target", c), oPredTarget, e_tg);
            chk($sformatf("rnd%0d mispredict", c), 32'(oMispredict), 32'(e_mis));
            @(posedge clk);
            m = m_nx;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
